// File: rtl/nx_mesh_ctrl.sv
// rtl/nx_mesh_ctrl.sv - round-robin inbound merge and quiet-gated trigger sequencer for the node mesh
module nx_mesh_ctrl #(
    parameter int REQUESTERS   = 2,
    parameter int STREAM_WIDTH = 32,
    parameter int CYCLE_WIDTH  = 16,
    parameter int IDLE_CYCLES  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [REQUESTERS*STREAM_WIDTH-1:0] req_data_i,
    input  logic [REQUESTERS-1:0]            req_valid_i,
    output logic [REQUESTERS-1:0]            req_ready_o,
    output logic [STREAM_WIDTH-1:0]          mesh_data_o,
    output logic                             mesh_valid_o,
    input  logic                             mesh_ready_i,
    input  logic                             mesh_ob_valid_i,
    input  logic                             run_i,
    input  logic [CYCLE_WIDTH-1:0]           cycles_i,
    output logic                             trigger_o,
    output logic                             busy_o,
    output logic [CYCLE_WIDTH-1:0]           trigger_count_o
);

    localparam int LGW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int QW  = $clog2(IDLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_TRIGGER} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [QW-1:0]           r_quiet;
    logic [QW-1:0]           w_quiet_nxt;
    logic [CYCLE_WIDTH-1:0]  r_remaining;
    logic [CYCLE_WIDTH-1:0]  w_remaining_nxt;
    logic [CYCLE_WIDTH-1:0]  r_trig_count;
    logic                    r_mesh_valid;
    logic [STREAM_WIDTH-1:0] r_mesh_data;
    logic [LGW-1:0]          r_last_grant;
    logic [REQUESTERS-1:0]   w_grant;
    logic [LGW-1:0]          w_grant_idx;
    logic                    w_found;
    logic                    w_free;
    logic                    w_activity;
    int                      w_j;

    // Output register can accept a new beat when empty or draining this cycle.
    assign w_free     = !r_mesh_valid || mesh_ready_i;
    assign w_activity = (|req_valid_i) || r_mesh_valid || mesh_ob_valid_i;

    // Round-robin search starting just after the last granted requester; no grants in the trigger cycle.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = r_last_grant;
        w_found     = 1'b0;
        w_j         = 0;
        if (w_free && (r_state != S_TRIGGER)) begin
            for (int i = 0; i < REQUESTERS; i++) begin
                w_j = int'(r_last_grant) + 1 + i;
                if (w_j >= REQUESTERS) w_j = w_j - REQUESTERS;
                if (!w_found && req_valid_i[w_j]) begin
                    w_found      = 1'b1;
                    w_grant[w_j] = 1'b1;
                    w_grant_idx  = LGW'(w_j);
                end
            end
        end
    end

    // One-entry output register: load on grant, clear on handshake, otherwise hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mesh_valid <= 1'b0;
            r_mesh_data  <= '0;
            r_last_grant <= LGW'(REQUESTERS - 1);
        end else if (w_found) begin
            r_mesh_valid <= 1'b1;
            r_mesh_data  <= req_data_i[w_grant_idx*STREAM_WIDTH +: STREAM_WIDTH];
            r_last_grant <= w_grant_idx;
        end else if (mesh_ready_i) begin
            r_mesh_valid <= 1'b0;
        end
    end

    // Sequencer next state: count quiet cycles in DRAIN, fire one trigger per requested cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_quiet_nxt     = r_quiet;
        w_remaining_nxt = r_remaining;
        case (r_state)
            S_IDLE: begin
                if (run_i && (cycles_i != '0)) begin
                    w_state_nxt     = S_DRAIN;
                    w_remaining_nxt = cycles_i;
                    w_quiet_nxt     = '0;
                end
            end
            S_DRAIN: begin
                if (w_activity) begin
                    w_quiet_nxt = '0;
                end else if (r_quiet >= QW'(IDLE_CYCLES - 1)) begin
                    w_quiet_nxt = QW'(IDLE_CYCLES);
                    w_state_nxt = S_TRIGGER;
                end else begin
                    w_quiet_nxt = r_quiet + 1'b1;
                end
            end
            S_TRIGGER: begin
                w_remaining_nxt = r_remaining - 1'b1;
                w_quiet_nxt     = '0;
                w_state_nxt     = (r_remaining == CYCLE_WIDTH'(1)) ? S_IDLE : S_DRAIN;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sequencer state, counters and lifetime trigger count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_quiet      <= '0;
            r_remaining  <= '0;
            r_trig_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_quiet     <= w_quiet_nxt;
            r_remaining <= w_remaining_nxt;
            if (r_state == S_TRIGGER) r_trig_count <= r_trig_count + 1'b1;
        end
    end

    assign req_ready_o     = w_grant;
    assign mesh_data_o     = r_mesh_data;
    assign mesh_valid_o    = r_mesh_valid;
    assign trigger_o       = (r_state == S_TRIGGER);
    assign busy_o          = (r_state != S_IDLE);
    assign trigger_count_o = r_trig_count;

endmodule
